instr_fetch_unit: RTL and testbench

- Owns the architectural PC and the instruction-memory read transaction for the multicycle core. It is the consumer side of the sequential next-PC path.
- On a fetch command from the control unit it reads the 16-bit word at PC over a req/ack handshake, latches it into IR and advances PC by 2.
- Branch/jump redirects from the execute stage overwrite PC. Stale in-flight fetches are discarded. A wait-cycle watchdog flags a memory that never acknowledges.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_watchdog.sv | 30 +++
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants for the multicycle core.
// The PC step constant is also used by the inline PC-increment logic.
package cpu_pkg;

  localparam int PC_WIDTH    = 16;
  localparam int INSTR_WIDTH = 16;
  localparam logic [PC_WIDTH-1:0] PC_STEP = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } fetch_state_e;

  // Instructions are halfword aligned, so bit 0 of any PC is always zero.
  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] addr);
    return {addr[PC_WIDTH-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Wait-cycle watchdog for the instruction-memory request.
// timeout fires on the last tolerated waiting cycle so the abort lands on the next edge.
module fetch_watchdog #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  logic [7:0] wait_cnt_r;

  // Counts cycles spent waiting for an acknowledge since the fetch started.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= 8'd0;
    end else if (clear) begin
      wait_cnt_r <= 8'd0;
    end else if (enable) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout = enable && (wait_cnt_r == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the architectural PC and the imem req/ack read.
// Redirects overwrite the PC at any time; a redirected in-flight fetch completes but is not delivered.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 16'h0000,
  parameter int                  MAX_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    pc_plus2,
  output logic                   busy,
  output logic                   fetch_err
);

  fetch_state_e           state_r, state_s;
  logic [PC_WIDTH-1:0]    pc_r, pc_s;
  logic [PC_WIDTH-1:0]    addr_r, addr_s;
  logic                   flush_r, flush_s;
  logic [INSTR_WIDTH-1:0] instr_r;
  logic [PC_WIDTH-1:0]    instr_pc_r;
  logic                   imem_req_r, busy_r, instr_valid_r, fetch_err_r;
  logic                   ir_load_s, valid_s, err_s;
  logic                   wd_clear_s, wd_enable_s, wd_timeout_s;

  assign wd_clear_s  = (state_r == ST_IDLE) && fetch_en && !redirect_valid;
  assign wd_enable_s = (state_r == ST_REQ) && !imem_ack;

  fetch_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .timeout (wd_timeout_s)
  );

  // Next-state, next-PC and event decode for the fetch FSM.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    addr_s    = addr_r;
    flush_s   = flush_r;
    ir_load_s = 1'b0;
    valid_s   = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (redirect_valid) begin
          pc_s = align_pc(redirect_target);
        end else if (fetch_en) begin
          addr_s  = pc_r;
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          pc_s    = align_pc(redirect_target);
          flush_s = 1'b1;
        end else begin
          pc_s = pc_r;
        end
        if (imem_ack) begin
          ir_load_s = 1'b1;
          // A redirect seen during this transaction (even on the ack edge) wins over the increment.
          if (flush_r || redirect_valid) begin
            flush_s = 1'b0;
            state_s = ST_IDLE;
          end else begin
            pc_s    = addr_r + PC_STEP;
            valid_s = 1'b1;
            state_s = ST_RESP;
          end
        end else if (wd_timeout_s) begin
          err_s   = 1'b1;
          flush_s = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (redirect_valid) begin
          pc_s = align_pc(redirect_target);
        end else begin
          pc_s = pc_r;
        end
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, PC and registered output updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      addr_r        <= 16'h0000;
      flush_r       <= 1'b0;
      instr_r       <= 16'h0000;
      instr_pc_r    <= 16'h0000;
      imem_req_r    <= 1'b0;
      busy_r        <= 1'b0;
      instr_valid_r <= 1'b0;
      fetch_err_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      addr_r        <= addr_s;
      flush_r       <= flush_s;
      imem_req_r    <= (state_s == ST_REQ);
      busy_r        <= (state_s != ST_IDLE);
      instr_valid_r <= valid_s;
      fetch_err_r   <= err_s;
      if (ir_load_s) begin
        instr_r    <= imem_rdata;
        instr_pc_r <= addr_r;
      end else begin
        instr_r    <= instr_r;
        instr_pc_r <= instr_pc_r;
      end
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = addr_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = instr_valid_r;
  assign pc          = pc_r;
  assign pc_plus2    = pc_r + PC_STEP;
  assign busy        = busy_r;
  assign fetch_err   = fetch_err_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_instr_fetch_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_req, instr_valid, busy, fetch_err;
  logic [15:0] imem_addr, instr, instr_pc, pc, pc_plus2;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(16'h0000), .MAX_WAIT(MW)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_pc        (instr_pc),
    .pc              (pc),
    .pc_plus2        (pc_plus2),
    .busy            (busy),
    .fetch_err       (fetch_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Transaction-level model: a fetch is either outstanding or not, plus a delivery pulse.
  logic [15:0] m_pc, m_faddr, m_instr, m_ipc;
  bit          m_inflight, m_redirected, m_deliver, m_err;
  int          m_waited;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task model_step;
    if (reset) begin
      m_pc = 16'h0000; m_faddr = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
      m_inflight = 1'b0; m_redirected = 1'b0; m_deliver = 1'b0; m_err = 1'b0;
      m_waited = 0;
    end else begin
      m_err = 1'b0;
      if (m_deliver) begin
        m_deliver = 1'b0;
        if (redirect_valid) m_pc = {redirect_target[15:1], 1'b0};
      end else if (!m_inflight) begin
        if (redirect_valid) m_pc = {redirect_target[15:1], 1'b0};
        else if (fetch_en) begin
          m_inflight = 1'b1; m_faddr = m_pc; m_waited = 0; m_redirected = 1'b0;
        end
      end else begin
        if (redirect_valid) m_pc = {redirect_target[15:1], 1'b0};
        if (imem_ack) begin
          m_instr = imem_rdata;
          m_ipc = m_faddr;
          m_inflight = 1'b0;
          if (!(m_redirected || redirect_valid)) begin
            m_pc = m_faddr + 16'd2;
            m_deliver = 1'b1;
          end
          m_redirected = 1'b0;
        end else begin
          m_waited++;
          if (m_waited == MW) begin
            m_inflight = 1'b0; m_err = 1'b1; m_redirected = 1'b0;
          end else if (redirect_valid) m_redirected = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("pc", pc, m_pc);
      chk("pc_plus2", pc_plus2, m_pc + 16'd2);
      chk("imem_req", {15'd0, imem_req}, {15'd0, m_inflight});
      if (m_inflight) chk("imem_addr", imem_addr, m_faddr);
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
      chk("instr_valid", {15'd0, instr_valid}, {15'd0, m_deliver});
      chk("busy", {15'd0, busy}, {15'd0, m_inflight | m_deliver});
      chk("fetch_err", {15'd0, fetch_err}, {15'd0, m_err});
    end
  end

  // Fetch with the ack raised d cycles after imem_req is first seen; returns on the pulse cycle.
  task automatic do_fetch(input int d, input logic [15:0] rd, input logic [15:0] exp_addr);
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    chk("dir_req", {15'd0, imem_req}, 16'd1);
    chk("dir_addr", imem_addr, exp_addr);
    repeat (d) @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = rd;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("dir_valid", {15'd0, instr_valid}, 16'd1);
    chk("dir_instr", instr, rd);
    chk("dir_instr_pc", instr_pc, exp_addr);
  endtask

  initial begin
    int req_cycles;
    int err_pulses;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk_on = 1'b1;
    reset = 1'b0;
    @(negedge clk);

    do_fetch(2, 16'hA5C3, 16'h0000);
    chk("f1_pc", pc, 16'h0002);
    chk("f1_pc_plus2", pc_plus2, 16'h0004);
    @(negedge clk);
    chk("f1_pulse_len", {15'd0, instr_valid}, 16'd0);

    redirect_valid = 1'b1; redirect_target = 16'h1235;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rd_idle_pc", pc, 16'h1234);
    do_fetch(0, 16'h1111, 16'h1234);
    chk("rd_idle_pc2", pc, 16'h1236);
    @(negedge clk);

    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    redirect_valid = 1'b1; redirect_target = 16'h0400;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("flush_no_valid", {15'd0, instr_valid}, 16'd0);
    chk("flush_pc", pc, 16'h0400);
    chk("flush_ir", instr, 16'hBEEF);
    do_fetch(1, 16'h2222, 16'h0400);
    @(negedge clk);

    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    req_cycles = 0;
    err_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (imem_req) req_cycles++;
      if (fetch_err) err_pulses++;
      @(negedge clk);
    end
    chk("wd_req_cycles", 16'(req_cycles), 16'd4);
    chk("wd_err_pulses", 16'(err_pulses), 16'd1);
    chk("wd_pc", pc, 16'h0402);
    chk("wd_busy", {15'd0, busy}, 16'd0);

    redirect_valid = 1'b1; redirect_target = 16'hFFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    do_fetch(1, 16'h7777, 16'hFFFE);
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_pc_plus2", pc_plus2, 16'h0002);
    @(negedge clk);

    redirect_valid = 1'b1; redirect_target = 16'h0800;
    @(negedge clk);
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h3333;
    @(negedge clk);
    chk("mid_rst_req", {15'd0, imem_req}, 16'd0);
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_valid", {15'd0, instr_valid}, 16'd0);
    reset = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid2", {15'd0, instr_valid}, 16'd0);

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(199) == 0);
      fetch_en = $urandom_range(1);
      redirect_valid = ($urandom_range(7) == 0);
      redirect_target = 16'($urandom);
      if (imem_req) imem_ack = ($urandom_range(9) < 4);
      else imem_ack = ($urandom_range(3) == 0);
      imem_rdata = 16'($urandom);
      @(negedge clk);
    end
    reset = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
